// File: rtl/morra_result_monitor.sv
// Morra Cinese result monitor: per-game round tally, game result, cross-game statistics, sticky error flags.
// Latency: every output is registered one clock after the sampled MANCHE/PARTITA/INIZIA cycle.
// Backpressure: none; the monitor observes the game stream every cycle and never stalls it.
module morra_result_monitor #(
    parameter int CNT_W   = 5,
    parameter int GAMES_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               INIZIA,
    input  logic [1:0]         MANCHE,
    input  logic [1:0]         PARTITA,
    output logic [CNT_W-1:0]   p1_manches,
    output logic [CNT_W-1:0]   p2_manches,
    output logic [CNT_W-1:0]   tie_manches,
    output logic [CNT_W-1:0]   invalid_manches,
    output logic               game_over,
    output logic [1:0]         winner,
    output logic               result_valid,
    output logic [GAMES_W-1:0] games_p1,
    output logic [GAMES_W-1:0] games_p2,
    output logic [GAMES_W-1:0] games_tie,
    output logic [GAMES_W-1:0] games_aborted,
    output logic               proto_err,
    output logic               cons_err
);

    localparam logic [1:0] S_IDLE    = 2'b00;
    localparam logic [1:0] S_PLAYING = 2'b01;
    localparam logic [1:0] S_OVER    = 2'b10;

    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [GAMES_W-1:0] GAMES_MAX = '1;
    localparam logic [GAMES_W-1:0] GAMES_ONE = GAMES_W'(1);

    function automatic logic [CNT_W-1:0] inc_cnt(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    function automatic logic [GAMES_W-1:0] inc_games(input logic [GAMES_W-1:0] v);
        return (v == GAMES_MAX) ? v : v + GAMES_ONE;
    endfunction

    logic [1:0]         state, state_n;
    logic [CNT_W-1:0]   p1_n, p2_n, tie_n, inv_n;
    logic [1:0]         winner_n;
    logic               rv_n, proto_n, cons_n;
    logic [GAMES_W-1:0] gp1_n, gp2_n, gtie_n, gab_n;

    always_comb begin
        state_n  = state;
        p1_n     = p1_manches;
        p2_n     = p2_manches;
        tie_n    = tie_manches;
        inv_n    = invalid_manches;
        winner_n = winner;
        rv_n     = 1'b0;
        proto_n  = proto_err;
        cons_n   = cons_err;
        gp1_n    = games_p1;
        gp2_n    = games_p2;
        gtie_n   = games_tie;
        gab_n    = games_aborted;

        case (state)
            S_PLAYING: begin
                // INIZIA takes priority over a simultaneous PARTITA: treated as an abort
                if (INIZIA) begin
                    gab_n = inc_games(games_aborted);
                    p1_n  = '0;
                    p2_n  = '0;
                    tie_n = '0;
                    inv_n = '0;
                end else begin
                    case (MANCHE)
                        2'b01:   p1_n  = inc_cnt(p1_manches);
                        2'b10:   p2_n  = inc_cnt(p2_manches);
                        2'b11:   tie_n = inc_cnt(tie_manches);
                        default: inv_n = inc_cnt(invalid_manches);
                    endcase
                    if (PARTITA != 2'b00) begin
                        state_n  = S_OVER;
                        winner_n = PARTITA;
                        rv_n     = 1'b1;
                        // Consistency is judged on counts that already include this cycle's round
                        case (PARTITA)
                            2'b01: begin
                                gp1_n = inc_games(games_p1);
                                if (!(p1_n > p2_n)) cons_n = 1'b1;
                            end
                            2'b10: begin
                                gp2_n = inc_games(games_p2);
                                if (!(p2_n > p1_n)) cons_n = 1'b1;
                            end
                            default: begin
                                gtie_n = inc_games(games_tie);
                                if (p1_n != p2_n) cons_n = 1'b1;
                            end
                        endcase
                    end
                end
            end
            default: begin
                // IDLE and OVER share handling; OVER simply keeps the last game's counters for readout
                if (INIZIA) begin
                    state_n = S_PLAYING;
                    p1_n    = '0;
                    p2_n    = '0;
                    tie_n   = '0;
                    inv_n   = '0;
                end else if (MANCHE != 2'b00 || PARTITA != 2'b00) begin
                    proto_n = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            p1_manches      <= '0;
            p2_manches      <= '0;
            tie_manches     <= '0;
            invalid_manches <= '0;
            winner          <= 2'b00;
            result_valid    <= 1'b0;
            games_p1        <= '0;
            games_p2        <= '0;
            games_tie       <= '0;
            games_aborted   <= '0;
            proto_err       <= 1'b0;
            cons_err        <= 1'b0;
        end else begin
            state           <= state_n;
            p1_manches      <= p1_n;
            p2_manches      <= p2_n;
            tie_manches     <= tie_n;
            invalid_manches <= inv_n;
            winner          <= winner_n;
            result_valid    <= rv_n;
            games_p1        <= gp1_n;
            games_p2        <= gp2_n;
            games_tie       <= gtie_n;
            games_aborted   <= gab_n;
            proto_err       <= proto_n;
            cons_err        <= cons_n;
        end
    end

    assign game_over = (state == S_OVER);

endmodule
